// File: rtl/multicycle_sequencer_pkg.sv
// Shared RV64 multicycle control definitions: opcodes, FSM states, ALU op codes, op classes.
// Combinational helpers only; no latency or backpressure of its own.
package riscv_ctrl_pkg;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_SD  = 7'b0100011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CL_R   = 3'd0,
        CL_I   = 3'd1,
        CL_LD  = 3'd2,
        CL_SD  = 3'd3,
        CL_BEQ = 3'd4,
        CL_ILL = 3'd5
    } op_class_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_t;

    // {alu_op, alu_src} for a class; held from EXEC through the end of the instruction
    function automatic logic [2:0] alu_setting(input op_class_t cls);
        logic [2:0] r;
        case (cls)
            CL_R:         r = {ALUOP_FUNCT, 1'b0};
            CL_I:         r = {ALUOP_FUNCT, 1'b1};
            CL_LD, CL_SD: r = {ALUOP_ADD,   1'b1};
            CL_BEQ:       r = {ALUOP_SUB,   1'b0};
            default:      r = 3'b000;
        endcase
        return r;
    endfunction

    function automatic logic is_mem_class(input op_class_t cls);
        return (cls == CL_LD) || (cls == CL_SD);
    endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Control/handshake bundle between the sequencer (master) and IR, memory port and datapath (slave).
// Pure wiring; timing and flow control are defined by the sequencer.
interface multicycle_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             halt_req;
    logic [31:0]      instruction;
    logic             zero;
    logic             mem_ready;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             pc_write;
    logic             pc_src;
    logic             alu_src;
    logic [1:0]       alu_op;
    logic             reg_write;
    logic             mem_to_reg;
    logic [2:0]       state;
    logic             illegal_op;
    logic             timeout_err;
    logic [CNT_W-1:0] retired_count;

    modport master (
        input  start, halt_req, instruction, zero, mem_ready,
        output mem_read, mem_write, ir_write, pc_write, pc_src, alu_src, alu_op,
               reg_write, mem_to_reg, state, illegal_op, timeout_err, retired_count
    );

    modport slave (
        output start, halt_req, instruction, zero, mem_ready,
        input  mem_read, mem_write, ir_write, pc_write, pc_src, alu_src, alu_op,
               reg_write, mem_to_reg, state, illegal_op, timeout_err, retired_count
    );
endinterface

// File: rtl/multicycle_sequencer_op_class_decoder.sv
// Opcode classifier shared with the datapath decoders: opcode[6:0] -> op class and legal flag.
// Purely combinational, zero latency, no flow control.
module op_class_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  op_class,
    output logic       legal
);
    always_comb begin
        case (opcode)
            OPC_R:   op_class = CL_R;
            OPC_I:   op_class = CL_I;
            OPC_LD:  op_class = CL_LD;
            OPC_SD:  op_class = CL_SD;
            OPC_BEQ: op_class = CL_BEQ;
            default: op_class = CL_ILL;
        endcase
        legal = (op_class != CL_ILL);
    end
endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle RV64 control FSM: one instruction at a time, beq 3 / R,I,sd 4 / ld 5 cycles plus memory waits.
// Stalls in FETCH/MEM until mem_ready; bounded by TIMEOUT_CYCLES (0 = wait forever).
module multicycle_sequencer
    import riscv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    multicycle_sequencer_if.master bus
);
    localparam int WC_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST =
        (TIMEOUT_CYCLES > 0) ? WC_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t           st;
    op_class_t        cls_q;
    op_class_t        dec_class;
    logic             dec_legal;
    logic [WC_W-1:0]  wait_cnt;
    logic [CNT_W-1:0] cnt_q;
    logic             ill_q;
    logic             to_q;
    logic             wait_expired;
    ctrl_t            ctrl;

    op_class_decoder u_dec (
        .opcode   (bus.instruction[6:0]),
        .op_class (dec_class),
        .legal    (dec_legal)
    );

    assign wait_expired = (TIMEOUT_CYCLES > 0) && !bus.mem_ready && (wait_cnt == WAIT_LAST);

    // Moore strobes from state/class, plus Mealy terms on mem_ready and zero
    always_comb begin
        ctrl = '0;
        case (st)
            ST_FETCH: begin
                ctrl.mem_read = 1'b1;
                ctrl.ir_write = bus.mem_ready;
            end
            ST_EXEC: begin
                {ctrl.alu_op, ctrl.alu_src} = alu_setting(cls_q);
                if (cls_q == CL_BEQ) begin
                    ctrl.pc_write = 1'b1;
                    ctrl.pc_src   = bus.zero;
                end
            end
            ST_MEM: begin
                {ctrl.alu_op, ctrl.alu_src} = alu_setting(cls_q);
                ctrl.mem_read  = (cls_q == CL_LD);
                ctrl.mem_write = (cls_q == CL_SD);
                ctrl.pc_write  = (cls_q == CL_SD) && bus.mem_ready;
            end
            ST_WB: begin
                {ctrl.alu_op, ctrl.alu_src} = alu_setting(cls_q);
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = (cls_q == CL_LD);
                ctrl.pc_write   = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            st       <= ST_IDLE;
            cls_q    <= CL_R;
            wait_cnt <= '0;
            cnt_q    <= '0;
            ill_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (bus.start && !bus.halt_req) begin
                        st       <= ST_FETCH;
                        wait_cnt <= '0;
                    end
                end
                ST_FETCH: begin
                    if (bus.mem_ready) begin
                        st <= ST_DECODE;
                    end else if (wait_expired) begin
                        st   <= ST_ERROR;
                        to_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                ST_DECODE: begin
                    cls_q <= dec_class;
                    if (dec_legal) begin
                        st <= ST_EXEC;
                    end else begin
                        st    <= ST_ERROR;
                        ill_q <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (is_mem_class(cls_q)) begin
                        st       <= ST_MEM;
                        wait_cnt <= '0;
                    end else if (cls_q != CL_BEQ) begin
                        st <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (bus.mem_ready) begin
                        if (cls_q == CL_LD) begin
                            st <= ST_WB;
                        end
                    end else if (wait_expired) begin
                        st   <= ST_ERROR;
                        to_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                ST_WB:    st <= st;
                ST_ERROR: st <= ST_ERROR;
                default:  st <= ST_ERROR;
            endcase

            // Retire overrides the per-state next state above
            if (ctrl.pc_write) begin
                cnt_q    <= cnt_q + CNT_W'(1);
                st       <= bus.halt_req ? ST_IDLE : ST_FETCH;
                wait_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(ctrl.mem_read && ctrl.mem_write));
        end
    end

    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_src        = ctrl.pc_src;
    assign bus.alu_src       = ctrl.alu_src;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.state         = st;
    assign bus.illegal_op    = ill_q;
    assign bus.timeout_err   = to_q;
    assign bus.retired_count = cnt_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench: transaction-level model expands each instruction into its expected cycle trace; one loop plays and compares.
module tb_multicycle_sequencer;
    import riscv_ctrl_pkg::*;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_sequencer_if #(.CNT_W(32)) bus ();
    multicycle_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(32)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    // exp = {state[2:0], rd, wr, iw, pw, ps, as, ao[1:0], rw, m2r, ill, to}
    typedef struct {
        logic        rst, start, halt, zero, mr;
        logic [31:0] instr;
        logic [14:0] exp;
        logic [31:0] cnt;
    } cyc_t;

    cyc_t        q[$];
    int          played = 0;
    int          checks = 0;
    int          failures = 0;
    logic        c_rst, c_start, c_halt, c_zero, c_mr;
    logic [31:0] c_instr;
    logic [31:0] m_cnt;
    logic        m_ill, m_to;
    int          n;

    task automatic add(input logic [2:0] st, input logic rd, wr, iw, pw, ps, as,
                       input logic [1:0] ao, input logic rw, m2r);
        cyc_t c;
        c.rst = c_rst; c.start = c_start; c.halt = c_halt;
        c.zero = c_zero; c.mr = c_mr; c.instr = c_instr;
        c.exp = {st, rd, wr, iw, pw, ps, as, ao, rw, m2r, m_ill, m_to};
        c.cnt = m_cnt;
        q.push_back(c);
        if (pw) m_cnt = m_cnt + 32'd1;
    endtask

    // 0 R, 1 I, 2 ld, 3 sd, 4 beq, 5 illegal
    function automatic int kind(input logic [6:0] op);
        if (op == 7'b0110011) return 0;
        if (op == 7'b0010011) return 1;
        if (op == 7'b0000011) return 2;
        if (op == 7'b0100011) return 3;
        if (op == 7'b1100011) return 4;
        return 5;
    endfunction

    // {alu_op, alu_src}
    function automatic logic [2:0] alu_of(input int k);
        if (k <= 1) return {2'b10, (k == 1)};
        if (k <= 3) return 3'b001;
        return 3'b010;
    endfunction

    task automatic idle(input int cycles, input logic start, input logic halt);
        c_rst = 1'b0; c_start = start; c_halt = halt; c_mr = 1'b0;
        for (int i = 0; i < cycles; i++) add(3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        c_start = 1'b0; c_halt = 1'b0;
    endtask

    task automatic err(input int cycles, input logic start);
        c_start = start;
        for (int i = 0; i < cycles; i++) add(3'd6, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        c_start = 1'b0;
    endtask

    task automatic rst_cycle(input logic [2:0] st);
        c_rst = 1'b1;
        add(st, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        c_rst = 1'b0; m_cnt = '0; m_ill = 1'b0; m_to = 1'b0;
    endtask

    // Expected trace of one instruction starting in FETCH; abort_at = MEM wait cycle carrying reset
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input logic z,
                             input logic halt_exec, input int abort_at, output int ncyc);
        int k, n0;
        logic [1:0] ao;
        logic as, ld, sd;
        n0 = q.size();
        k = kind(ins[6:0]);
        {ao, as} = alu_of(k);
        ld = (k == 2); sd = (k == 3);
        c_instr = ins; c_start = 1'b0; c_halt = 1'b0; c_zero = z; c_rst = 1'b0;
        ncyc = 0;
        for (int i = 0; i < fw; i++) begin
            c_mr = 1'b0;
            add(3'd1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
            if (i == TO - 1) begin m_to = 1'b1; ncyc = q.size() - n0; return; end
        end
        c_mr = 1'b1;
        add(3'd1, 1, 0, 1, 0, 0, 0, 2'b00, 0, 0);
        add(3'd2, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        if (k == 5) begin m_ill = 1'b1; ncyc = q.size() - n0; return; end
        c_halt = halt_exec;
        add(3'd3, 0, 0, 0, k == 4, (k == 4) && z, as, ao, 0, 0);
        if (ld || sd) begin
            for (int i = 0; i < mw; i++) begin
                c_mr = 1'b0;
                c_rst = (i == abort_at);
                add(3'd4, ld, sd, 0, 0, 0, as, ao, 0, 0);
                if (c_rst) begin
                    c_rst = 1'b0; m_cnt = '0; m_ill = 1'b0; m_to = 1'b0;
                    ncyc = q.size() - n0; return;
                end
                if (i == TO - 1) begin m_to = 1'b1; ncyc = q.size() - n0; return; end
            end
            c_mr = 1'b1;
            add(3'd4, ld, sd, 0, sd, 0, as, ao, 0, 0);
        end
        if (k <= 2) add(3'd5, 0, 0, 0, 1, 0, as, ao, 1, ld);
        c_halt = 1'b0;
        ncyc = q.size() - n0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic play();
        cyc_t c;
        logic [14:0] act;
        while (played < q.size()) begin
            c = q[played];
            @(posedge clk);
            #1;
            rst = c.rst; bus.start = c.start; bus.halt_req = c.halt;
            bus.instruction = c.instr; bus.zero = c.zero; bus.mem_ready = c.mr;
            @(negedge clk);
            act = {bus.state, bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write,
                   c.exp[8] ? bus.pc_src : 1'b0, bus.alu_src, bus.alu_op,
                   bus.reg_write, bus.mem_to_reg, bus.illegal_op, bus.timeout_err};
            checks++;
            if (act !== c.exp) begin
                failures++;
                $display("FAIL cyc%0d ctrl actual=%b required=%b", played, act, c.exp);
            end
            checks++;
            if (bus.retired_count !== c.cnt) begin
                failures++;
                $display("FAIL cyc%0d count actual=%0d required=%0d", played, bus.retired_count, c.cnt);
            end
            played++;
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.halt_req = 1'b0; bus.instruction = '0;
        bus.zero = 1'b0; bus.mem_ready = 1'b0;
        c_rst = 1'b0; c_start = 1'b0; c_halt = 1'b0; c_zero = 1'b0; c_mr = 1'b0;
        c_instr = '0; m_cnt = '0; m_ill = 1'b0; m_to = 1'b0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_strobes", 32'({bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write,
                                bus.alu_src, bus.alu_op, bus.reg_write, bus.mem_to_reg}), 32'd0);
        chk("rst_count", bus.retired_count, 32'd0);
        chk("rst_flags", 32'({bus.illegal_op, bus.timeout_err}), 32'd0);

        // R add, zero-wait memory, halt at retire
        idle(1, 1, 0);
        run_instr(32'h00208033, 0, 0, 0, 1, -1, n);
        chk("model_r_len", n, 4);
        idle(1, 0, 0);
        play();
        chk("r_count", bus.retired_count, 32'd1);

        // beq taken then not taken
        idle(1, 1, 0);
        run_instr(32'h00208463, 0, 0, 1, 0, -1, n);
        chk("model_beq_len", n, 3);
        run_instr(32'h00208463, 0, 0, 0, 1, -1, n);
        idle(1, 0, 0);
        play();
        chk("beq_count", bus.retired_count, 32'd3);

        // start+halt together stays idle; ld and sd with 2 MEM wait cycles
        idle(1, 1, 1);
        idle(1, 1, 0);
        run_instr(32'h00003083, 0, 2, 0, 0, -1, n);
        chk("model_ld_len", n, 7);
        run_instr(32'h00103023, 0, 2, 0, 1, -1, n);
        chk("model_sd_len", n, 6);
        idle(1, 0, 0);
        play();
        chk("ldsd_count", bus.retired_count, 32'd5);

        // FETCH wait of 3, ready on the 4th cycle: no timeout
        idle(1, 1, 0);
        run_instr(32'h00100093, 3, 0, 0, 1, -1, n);
        chk("model_fetch_wait_len", n, 7);
        idle(1, 0, 0);
        play();
        chk("late_ready_noerr", 32'(bus.timeout_err), 32'd0);

        // FETCH timeout, start ignored in ERROR
        idle(1, 1, 0);
        run_instr(32'h00208033, 4, 0, 0, 0, -1, n);
        err(3, 1);
        play();
        chk("timeout_flag", 32'(bus.timeout_err), 32'd1);
        chk("timeout_state", 32'(bus.state), 32'd6);
        rst_cycle(3'd6);
        idle(1, 0, 0);

        // illegal opcode
        idle(1, 1, 0);
        run_instr(32'hFFFFFFFF, 0, 0, 0, 0, -1, n);
        err(3, 1);
        play();
        chk("illegal_flag", 32'(bus.illegal_op), 32'd1);
        chk("illegal_count", bus.retired_count, 32'd0);
        rst_cycle(3'd6);
        idle(1, 0, 0);

        // halt during EXEC, then reset mid-MEM of a ld
        idle(1, 1, 0);
        run_instr(32'h00208033, 0, 0, 0, 1, -1, n);
        idle(1, 0, 0);
        idle(1, 1, 0);
        run_instr(32'h00003083, 0, 5, 0, 0, 1, n);
        idle(2, 0, 0);
        play();
        chk("abort_state", 32'(bus.state), 32'd0);
        chk("abort_count", bus.retired_count, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
